// File: rtl/ysyx_22041071_hzd_ctrl.sv
// Hazard controller: outstanding-load scoreboard, load-use detection and
// IF/ID/EX stall/bubble/flush sequencing across redirect and memory waits.
module ysyx_22041071_hzd_sb_cnt #(
  parameter int SB_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic err
);
  logic [SB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == {SB_W{1'b1}}) err = 1'b1;
      else                       cnt_d = cnt_q + SB_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - SB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
endmodule

module ysyx_22041071_hzd_ctrl #(
  parameter int SB_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_ren,
  input  logic             id_rs2_ren,
  input  logic [4:0]       id_rd,
  input  logic             id_load,
  input  logic             ex_ready,
  input  logic             wb_load_done,
  input  logic [4:0]       wb_rd,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             id_issue,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [31:0]      sb_busy,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_MEMWAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             pend_redir_q, pend_redir_d;
  logic             sb_err_q, sb_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]      cnt_err;
  logic             hazard, inc_en, dec_en;

  assign inc_en = id_issue & id_load & (id_rd != 5'd0);
  assign dec_en = wb_load_done & (wb_rd != 5'd0);

  // x0 is hardwired, so slot 0 never holds a counter
  assign sb_busy[0] = 1'b0;
  assign cnt_err[0] = 1'b0;
  for (genvar i = 1; i < 32; i++) begin : g_sb
    ysyx_22041071_hzd_sb_cnt #(.SB_W(SB_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_en && (id_rd == 5'(i))),
      .dec   (dec_en && (wb_rd == 5'(i))),
      .busy  (sb_busy[i]),
      .err   (cnt_err[i])
    );
  end

  assign hazard = id_valid &
                  ((id_rs1_ren & (id_rs1 != 5'd0) & sb_busy[id_rs1]) |
                   (id_rs2_ren & (id_rs2 != 5'd0) & sb_busy[id_rs2]));

  always_comb begin
    state_d      = state_q;
    pend_redir_d = pend_redir_q;
    id_issue     = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          pend_redir_d = redirect;
          state_d      = S_MEMWAIT;
        end else if (redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = ex_ready;
          state_d      = S_FLUSH;
        end else begin
          id_issue     = id_valid & ~hazard & ex_ready;
          pc_stall     = id_valid & ~id_issue;
          if_id_stall  = id_valid & ~id_issue;
          id_ex_bubble = ex_ready & ~id_issue;
        end
      end
      S_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = ex_ready;
        state_d      = mem_busy ? S_MEMWAIT : S_RUN;
      end
      S_MEMWAIT: begin
        // the pipe stays frozen on the release cycle; a remembered redirect
        // is then serviced by the FLUSH state
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        if (mem_busy) begin
          pend_redir_d = pend_redir_q | redirect;
        end else begin
          state_d      = (pend_redir_q | redirect) ? S_FLUSH : S_RUN;
          pend_redir_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (reset) begin
      id_issue     = 1'b0;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
    end
  end

  always_comb begin
    sb_err_d    = sb_err_q | (|cnt_err);
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_issue && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      pend_redir_q <= 1'b0;
      sb_err_q     <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_redir_q <= pend_redir_d;
      sb_err_q     <= sb_err_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign sb_err    = sb_err_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_ysyx_22041071_hzd_ctrl.sv
// Directed bench for the hazard controller: load-use, redirect, memory wait,
// scoreboard edge cases, stall counter saturation and reset recovery.
module tb_ysyx_22041071_hzd_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_rs1_ren, id_rs2_ren, id_load;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        ex_ready, wb_load_done, redirect, mem_busy;
  logic        id_issue, pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [31:0] sb_busy;
  logic        sb_err;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22041071_hzd_ctrl #(.SB_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren), .id_rd(id_rd), .id_load(id_load),
    .ex_ready(ex_ready), .wb_load_done(wb_load_done), .wb_rd(wb_rd), .redirect(redirect),
    .mem_busy(mem_busy), .id_issue(id_issue), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .sb_busy(sb_busy),
    .sb_err(sb_err), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one cycle; inputs then change 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outputs are combinational: let them settle before checking
  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; id_rd = 5'd0; id_load = 1'b0;
    ex_ready = 1'b1; wb_load_done = 1'b0; wb_rd = 5'd0; redirect = 1'b0; mem_busy = 1'b0;
    settle();
    chk("rst_issue", 32'(id_issue), 32'd0);
    chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
    chk("rst_pc_stall", 32'(pc_stall), 32'd0);
    tick(); tick();
    reset = 1'b0; id_valid = 1'b0;
    settle();
    chk("rst_sb_busy", sb_busy, 32'd0);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // load x5 then dependent add
    tick();
    id_valid = 1'b1; id_load = 1'b1; id_rd = 5'd5;
    settle();
    chk("ld_issue", 32'(id_issue), 32'd1);
    tick();
    id_load = 1'b0; id_rd = 5'd6; id_rs1 = 5'd5; id_rs1_ren = 1'b1;
    settle();
    chk("lu_busy5", 32'(sb_busy[5]), 32'd1);
    chk("lu_issue", 32'(id_issue), 32'd0);
    chk("lu_pc_stall", 32'(pc_stall), 32'd1);
    chk("lu_ifid_stall", 32'(if_id_stall), 32'd1);
    chk("lu_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    wb_load_done = 1'b1; wb_rd = 5'd5;
    settle();
    chk("lu_wb_cycle_issue", 32'(id_issue), 32'd0);
    tick();
    wb_load_done = 1'b0;
    settle();
    chk("lu_release_issue", 32'(id_issue), 32'd1);
    chk("lu_release_busy", sb_busy, 32'd0);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd2);
    tick();

    // redirect in RUN: two flush cycles
    id_rs1_ren = 1'b0; redirect = 1'b1;
    settle();
    chk("rd0_flush", 32'(if_id_flush), 32'd1);
    chk("rd0_issue", 32'(id_issue), 32'd0);
    chk("rd0_pc_stall", 32'(pc_stall), 32'd0);
    chk("rd0_bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    redirect = 1'b0;
    settle();
    chk("rd1_flush", 32'(if_id_flush), 32'd1);
    chk("rd1_issue", 32'(id_issue), 32'd0);
    tick();
    settle();
    chk("rd2_flush", 32'(if_id_flush), 32'd0);
    chk("rd2_issue", 32'(id_issue), 32'd1);
    tick();

    // mem_busy for 4 cycles, redirect in the second
    id_valid = 1'b0; mem_busy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      redirect = (c == 2);
      settle();
      chk($sformatf("mw%0d_pc_stall", c), 32'(pc_stall), 32'd1);
      chk($sformatf("mw%0d_ifid_stall", c), 32'(if_id_stall), 32'd1);
      chk($sformatf("mw%0d_flush", c), 32'(if_id_flush), 32'd0);
      chk($sformatf("mw%0d_bubble", c), 32'(id_ex_bubble), 32'd0);
      tick();
    end
    redirect = 1'b0; mem_busy = 1'b0;
    settle();
    chk("mw_exit_issue", 32'(id_issue), 32'd0);
    tick();
    settle();
    chk("mw_flush", 32'(if_id_flush), 32'd1);
    chk("mw_flush_issue", 32'(id_issue), 32'd0);
    tick();
    id_valid = 1'b1;
    settle();
    chk("mw_run_flush", 32'(if_id_flush), 32'd0);
    chk("mw_run_issue", 32'(id_issue), 32'd1);
    tick();

    // load to x0 is not tracked, x0 read never stalls
    id_load = 1'b1; id_rd = 5'd0;
    settle();
    chk("x0_ld_issue", 32'(id_issue), 32'd1);
    tick();
    id_load = 1'b0; id_rs1 = 5'd0; id_rs1_ren = 1'b1;
    settle();
    chk("x0_busy", sb_busy, 32'd0);
    chk("x0_issue", 32'(id_issue), 32'd1);
    tick();

    // same-cycle inc/dec on x7, then underflow on x9
    id_rs1_ren = 1'b0; id_load = 1'b1; id_rd = 5'd7;
    tick();
    wb_load_done = 1'b1; wb_rd = 5'd7;
    settle();
    chk("x7_both_issue", 32'(id_issue), 32'd1);
    tick();
    id_valid = 1'b0; id_load = 1'b0;
    settle();
    chk("x7_busy_after_both", 32'(sb_busy[7]), 32'd1);
    tick();
    wb_load_done = 1'b0;
    settle();
    chk("x7_drained", 32'(sb_busy[7]), 32'd0);
    chk("x7_no_err", 32'(sb_err), 32'd0);
    wb_load_done = 1'b1; wb_rd = 5'd9;
    tick();
    wb_load_done = 1'b0;
    settle();
    chk("x9_underflow_err", 32'(sb_err), 32'd1);
    chk("x9_busy", sb_busy, 32'd0);
    tick(); tick();
    chk("err_sticky", 32'(sb_err), 32'd1);
    chk("stall_cnt_mid", 32'(stall_cnt), 32'd4);

    // saturate the stall counter
    id_valid = 1'b1; ex_ready = 1'b0;
    settle();
    chk("sat_issue", 32'(id_issue), 32'd0);
    chk("sat_pc_stall", 32'(pc_stall), 32'd1);
    chk("sat_bubble", 32'(id_ex_bubble), 32'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
    tick();
    chk("stall_cnt_hold", 32'(stall_cnt), 32'h0000_FFFF);

    // reset during MEMWAIT returns to RUN and clears everything
    id_valid = 1'b0; ex_ready = 1'b1; mem_busy = 1'b1; redirect = 1'b1;
    tick();
    reset = 1'b1; redirect = 1'b0;
    settle();
    chk("rst_mw_pc_stall", 32'(pc_stall), 32'd0);
    chk("rst_mw_ifid_stall", 32'(if_id_stall), 32'd0);
    tick();
    reset = 1'b0; mem_busy = 1'b0; id_valid = 1'b1;
    settle();
    chk("post_rst_issue", 32'(id_issue), 32'd1);
    chk("post_rst_flush", 32'(if_id_flush), 32'd0);
    chk("post_rst_err", 32'(sb_err), 32'd0);
    chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    settle();
    chk("post_rst_no_flush", 32'(if_id_flush), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
